// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_pkg
//  Purpose  : Shared TLB definitions: walker state encoding, PTE field
//             positions and the default page-table base address.
//  Revision : 1.0  initial release
// ============================================================================
package tlb_pkg;

    // Refill walker states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;

    // PTE layout: bit 15 = valid, bits 14:0 = physical page number
    localparam int PTE_VALID_BIT = 15;
    localparam int PTE_PPN_MSB   = 14;

    // Page-table base word address
    localparam logic [15:0] DEFAULT_PT_BASE = 16'h0040;

endpackage : tlb_pkg
`default_nettype wire

// File: rtl/tlb_victim_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_victim_ptr
//  Purpose  : Round-robin TLB victim slot pointer. clear wins over inc;
//             the pointer wraps naturally because ENTRIES is a power of two.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_victim_ptr #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [IDX_W-1:0] ptr
);

    logic [IDX_W-1:0] ptr_q;

    // Victim pointer: reset/clear to slot 0, advance one slot per write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + IDX_W'(1);
        end
    end

    assign ptr = ptr_q;

endmodule : tlb_victim_ptr
`default_nettype wire

// File: rtl/tlb_refill_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_refill_walker
//  Purpose  : Instruction-TLB refill engine. On a miss, reads the PTE from
//             the page table, checks the valid bit and writes the VPN->PPN
//             pair into a round-robin chosen TLB slot. Also services
//             invalidate-all requests, deferring them while a walk is active.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_refill_walker
    import tlb_pkg::*;
#(
    parameter int          VPN_W   = 6,
    parameter int          PPN_W   = 15,
    parameter int          ENTRIES = 8,
    parameter logic [15:0] PT_BASE = DEFAULT_PT_BASE,
    parameter int          TIMEOUT = 15,
    parameter int          IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req,
    input  logic [VPN_W-1:0] miss_vpn,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic             mem_rd,
    output logic [15:0]      mem_addr,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_idx,
    output logic [VPN_W-1:0] tlb_vpn,
    output logic [PPN_W-1:0] tlb_ppn,
    output logic             tlb_flush
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [VPN_W-1:0] vpn_q;
    logic [15:0]      pte_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             fault_q;
    logic             flush_pend;
    logic             flush_any;
    logic             tmo_last;
    logic [IDX_W-1:0] ptr;

    // A flush request either arrives now or was parked during a walk
    assign flush_any = flush | flush_pend;
    // Final REQ cycle: the wait budget is exhausted after this one
    assign tmo_last  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush_any)     state_nxt = ST_FLUSH;
                else if (miss_req) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ready)     state_nxt = ST_CHECK;
                else if (tmo_last) state_nxt = ST_DONE;
            end
            ST_CHECK: state_nxt = pte_q[PTE_VALID_BIT] ? ST_WRITE : ST_DONE;
            ST_WRITE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Walk context: VPN latch, PTE capture, wait counter and fault verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpn_q   <= '0;
            pte_q   <= '0;
            tmo_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    fault_q <= 1'b0;
                    if (!flush_any && miss_req) vpn_q <= miss_vpn;
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        pte_q <= mem_rdata;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_last) fault_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!pte_q[PTE_VALID_BIT]) fault_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky flush request: parked while busy, consumed on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else if (state == ST_IDLE || state == ST_FLUSH) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

    tlb_victim_ptr #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_victim_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == ST_WRITE),
        .clear (state == ST_FLUSH),
        .ptr   (ptr)
    );

    // Output decode; data buses are held at zero outside their strobe
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        fault     = (state == ST_DONE) && fault_q;
        mem_rd    = (state == ST_REQ);
        mem_addr  = mem_rd ? (PT_BASE + 16'(vpn_q)) : 16'h0000;
        tlb_we    = (state == ST_WRITE);
        tlb_idx   = tlb_we ? ptr : '0;
        tlb_vpn   = tlb_we ? vpn_q : '0;
        tlb_ppn   = tlb_we ? pte_q[PPN_W-1:0] : '0;
        tlb_flush = (state == ST_FLUSH);
    end

endmodule : tlb_refill_walker
`default_nettype wire
